// File: rtl/stripes_pkg.sv
// Shared types and helpers for the Stripes serial inner-product slice control.
package stripes_pkg;

  localparam int unsigned PREC_W = 5;
  localparam logic [PREC_W-1:0] MAX_PREC = 5'd16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StDrain
  } state_e;

  // Precision 0 and anything above the slice's bit-slice capacity run at full width.
  function automatic logic [PREC_W-1:0] eff_precision(input logic [PREC_W-1:0] p);
    return ((p == '0) || (p > MAX_PREC)) ? MAX_PREC : p;
  endfunction

endpackage

// File: rtl/sis_delay_line.sv
// Aligns the MSB-slice marker with the accumulator input after the adder-tree pipeline.
module sis_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_out
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_out = r_sr[DEPTH-1];

endmodule

// File: rtl/serial_ip_sequencer.sv
// Brick-by-brick control sequencer for one Stripes serial inner-product slice.
module serial_ip_sequencer
  import stripes_pkg::*;
#(
  parameter int unsigned TW       = 16,
  parameter int unsigned BRICK_W  = 12,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [PREC_W-1:0]    i_cfg_precision,
  input  logic [BRICK_W-1:0]   i_cfg_bricks,
  input  logic                 i_cfg_max,
  input  logic                 i_syn_valid,
  input  logic                 i_nrn_valid,
  output logic                 o_syn_rd,
  output logic [TW-1:0]        o_load,
  output logic                 o_nrn_rd,
  output logic                 o_first_cycle,
  output logic                 o_acc_first,
  output logic                 o_nbout_rd,
  output logic                 o_nbout_wr,
  output logic                 o_max,
  output logic [PREC_W-1:0]    o_precision,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [PREC_W-1:0] DrainLast = PREC_W'(PIPE_LAT);

  state_e               r_state, w_state_d;
  logic [PREC_W-1:0]    r_cnt, w_cnt_d;
  logic [PREC_W-1:0]    r_prec, w_prec_d;
  logic [BRICK_W-1:0]   r_bricks, w_bricks_d;
  logic                 r_max, w_max_d;
  logic                 r_done_empty, w_done_empty_d;
  logic                 w_first_cycle;
  logic                 w_delayed_first;
  logic                 w_done_brick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_prec       <= '0;
      r_bricks     <= '0;
      r_max        <= 1'b0;
      r_done_empty <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_prec       <= w_prec_d;
      r_bricks     <= w_bricks_d;
      r_max        <= w_max_d;
      r_done_empty <= w_done_empty_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_prec_d       = r_prec;
    w_bricks_d     = r_bricks;
    w_max_d        = r_max;
    w_done_empty_d = 1'b0;
    o_cfg_ready    = 1'b0;
    o_syn_rd       = 1'b0;
    o_load         = '0;
    o_nrn_rd       = 1'b0;
    o_nbout_wr     = 1'b0;
    w_first_cycle  = 1'b0;
    w_done_brick   = 1'b0;

    unique case (r_state)
      StIdle: begin
        // An empty job's done pulse must be seen before the next job is taken.
        o_cfg_ready = ~r_done_empty & ~reset;
        if (i_cfg_valid && o_cfg_ready) begin
          w_prec_d   = eff_precision(i_cfg_precision);
          w_max_d    = i_cfg_max;
          w_bricks_d = i_cfg_bricks;
          if (i_cfg_bricks == '0) begin
            w_done_empty_d = 1'b1;
          end else begin
            w_state_d = StLoad;
          end
        end
      end

      StLoad: begin
        // The datapath accumulates every clock, so both buffers must be ready together.
        if (i_syn_valid && i_nrn_valid) begin
          o_syn_rd  = 1'b1;
          o_load    = '1;
          w_cnt_d   = '0;
          w_state_d = StStream;
        end
      end

      StStream: begin
        o_nrn_rd      = 1'b1;
        w_first_cycle = (r_cnt == '0);
        if (r_cnt == r_prec - PREC_W'(1)) begin
          w_cnt_d   = '0;
          w_state_d = StDrain;
        end else begin
          w_cnt_d = r_cnt + PREC_W'(1);
        end
      end

      StDrain: begin
        if (r_cnt == DrainLast) begin
          o_nbout_wr = 1'b1;
          w_bricks_d = r_bricks - BRICK_W'(1);
          w_cnt_d    = '0;
          if (r_bricks == BRICK_W'(1)) begin
            w_done_brick = 1'b1;
            w_state_d    = StIdle;
          end else begin
            w_state_d = StLoad;
          end
        end else begin
          w_cnt_d = r_cnt + PREC_W'(1);
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  sis_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .i_in  (w_first_cycle),
    .o_out (w_delayed_first)
  );

  assign o_first_cycle = w_first_cycle;
  assign o_acc_first   = w_delayed_first;
  assign o_nbout_rd    = w_delayed_first;
  assign o_done        = w_done_brick | r_done_empty;
  assign o_busy        = (r_state != StIdle);
  assign o_max         = r_max;
  assign o_precision   = r_prec;

endmodule

// File: doc/serial_ip_sequencer.md
# serial_ip_sequencer

Control sequencer for one Stripes serial inner-product slice (Tw windows × Ti lanes, Tn=1). It accepts a layer job (precision, brick count, max-pool mode) and runs the slice brick by brick. For each brick it latches synapses, streams P neuron bit-slices MSB-first, times the accumulator's first-cycle and NBout read against the adder-tree pipeline, and writes the partial sum back to NBout. It sits between the NBin/SB/NBout buffer controllers and the slice datapath.

## Interface
- TW, 16, windows per slice (width of load vector)
- BRICK_W, 12, width of brick-count field
- PIPE_LAT, 1, adder-tree pipeline registers between complement stage and accumulator (1..3)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_cfg_valid  in  1  job offered
- o_cfg_ready  out  1  job accepted when valid&ready
- i_cfg_precision  in  5  neuron bits P; 0 or >16 treated as 16
- i_cfg_bricks  in  BRICK_W  bricks per job; 0 = empty job
- i_cfg_max  in  1  max-pool mode for this job
- i_syn_valid  in  1  SB has next synapse brick
- i_nrn_valid  in  1  NBin has all P bit-slices of next brick
- o_syn_rd  out  1  pop synapse brick
- o_load  out  TW  synapse latch enable to datapath
- o_nrn_rd  out  1  pop one neuron bit-slice
- o_first_cycle  out  1  MSB slice on datapath (two's-complement select)
- o_acc_first  out  1  accumulator takes tree+nbout
- o_nbout_rd  out  1  NBout read; data valid same cycle
- o_nbout_wr  out  1  write accumulator result to NBout
- o_max  out  1  registered job max mode
- o_precision  out  5  registered effective P (1..16)
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse, job complete

## Operation
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE: o_cfg_ready=1. On accept, register P, bricks, and max. If bricks=0, pulse o_done next cycle and stay in IDLE. Otherwise go to LOAD.
- LOAD: wait until i_syn_valid & i_nrn_valid. In that cycle assert o_syn_rd and o_load=all ones, clear bit counter, then go to STREAM. A brick never starts without both valids, because the datapath accumulator updates every clock and cannot stall.
- STREAM: exactly P cycles with o_nrn_rd=1 in each. o_first_cycle=1 on the first cycle only. Then go to DRAIN.
- o_acc_first and o_nbout_rd are o_first_cycle delayed PIPE_LAT cycles through a shift register. They are independent of state so they may land in DRAIN when P ≤ PIPE_LAT.
- DRAIN: PIPE_LAT+1 cycles. o_nbout_wr=1 in the last cycle. Decrement the remaining-brick count there. If the count hits 0, assert o_done in the same cycle and go to IDLE; otherwise go to LOAD.
- o_max and o_precision hold the job values from accept until the next accept.
- Arithmetic: bit counter 5 bits, compared against P-1. Brick counter BRICK_W bits, no wrap (loaded, decremented to 0).

## Timing
- Reset: all outputs 0 except o_cfg_ready=1 the cycle after reset deasserts. State returns to IDLE and the delay line clears. A reset mid-brick discards the brick with no o_nbout_wr.
- Job accepted at cycle 0 with valids high: LOAD at 1, STREAM 1+1..1+P, DRAIN through P+2+PIPE_LAT. First o_nbout_wr at P+2+PIPE_LAT.
- Brick period with no stalls is P+PIPE_LAT+2 cycles. A LOAD stall adds cycles only in LOAD.
- i_cfg_valid while busy is ignored (o_cfg_ready=0). A new job is accepted earliest the cycle after o_done.
- Valids dropping during STREAM/DRAIN are ignored.

## Structure
- Shared package stripes_pkg: state enum, PREC_W=5, MAX_PREC=16, and the effective-precision function (0/>16 → 16).
- One sub-module, sis_delay_line: PIPE_LAT-deep shift register producing o_acc_first/o_nbout_rd. Everything else is in the top FSM.

## Test plan
- P=8, bricks=1, PIPE_LAT=1, valids high → o_load@1, o_first_cycle@2, o_acc_first/o_nbout_rd@3, o_nrn_rd 2..9, o_nbout_wr+o_done@11.
- P=16, bricks=3 → three o_nbout_wr spaced 19 cycles apart, o_done with the third, 48 o_nrn_rd pulses total.
- i_syn_valid low 5 cycles in LOAD of brick 2 → wr spacing 11→16 for that brick only; no o_nrn_rd or o_first_cycle during stall.
- i_cfg_precision=0, then 20 → o_precision=16, 16 STREAM cycles; bricks=0 → o_done the cycle after accept, no o_load.
- Reset asserted at STREAM cycle 3 → next cycle all outputs 0, IDLE, no o_nbout_wr; new job runs cleanly.
- P=1, PIPE_LAT=3 → o_acc_first lands in DRAIN 3 cycles after o_first_cycle, o_nbout_wr one cycle later.
